// File: rtl/pkt_readout_ctrl.sv
// Purpose : arms an ADC capture, then reads the capture memory back and frames it into
//           fixed-length packets separated by programmable idle gaps on the pad bus.
// Latency : cap_req 1 cycle after a start edge; ADC_DATA_VALID trails mem_rd_en by 2 cycles.
// Flow    : no backpressure; the pad bus is free-running and the memory answers every read.
//
// Ports:
//   pktctrl_clk / pktctrl_rstn      block clock, synchronous active-low reset
//   rf_capture_start / _again       level inputs; rising edges start capture+readout / replay
//   rf_self_test_mode               substitute {3'b101, address} for memory data
//   rf_pkt_data_length              packet length code (256 << code words)
//   rf_pkt_idle_length              idle cycles between packets (0 treated as 1)
//   cap_req / cap_done              capture handshake pulses to/from the capture writer
//   mem_rd_en / mem_rd_addr / mem_rd_data   capture memory read port (1-cycle read latency)
//   ADC_DATA / ADC_DATA_VALID       registered pad bus
//   busy / pkt_cnt                  status: sequencer active, packets sent this run
module pkt_readout_ctrl #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 18,
  parameter int MEM_DEPTH = 32768
) (
  input  logic              pktctrl_clk,
  input  logic              pktctrl_rstn,
  input  logic              rf_capture_start,
  input  logic              rf_capture_again,
  input  logic              rf_self_test_mode,
  input  logic [1:0]        rf_pkt_data_length,
  input  logic [15:0]       rf_pkt_idle_length,
  output logic              cap_req,
  input  logic              cap_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] ADC_DATA,
  output logic              ADC_DATA_VALID,
  output logic              busy,
  output logic [15:0]       pkt_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CAP,
    S_BURST,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic              start_d, again_d;
  logic              rel_q;          // low during the first cycle after reset release
  logic [ADDR_W-1:0] addr;
  logic [11:0]       word_cnt;
  logic [15:0]       gap_cnt;
  logic [11:0]       len_q;
  logic [15:0]       idle_q;
  logic              st_q;
  logic              rd_en_d1;
  logic [ADDR_W-1:0] rd_addr_d1;

  logic              start_pe, again_pe;
  logic              last_word, last_addr, gap_end;
  logic              latch_cfg, clr_run, cap_req_nx;
  logic [DATA_W-1:0] st_word;

  // Edges are gated off in the first cycle after reset release: the _d registers
  // reload from the live level there, so a level held through reset must drop
  // and rise again before it is accepted.
  assign start_pe  = rf_capture_start & ~start_d & rel_q;
  assign again_pe  = rf_capture_again & ~again_d & rel_q;

  assign last_word = (word_cnt == len_q - 12'd1);
  assign last_addr = (addr == ADDR_W'(MEM_DEPTH - 1));
  assign gap_end   = (gap_cnt == idle_q - 16'd1);

  assign st_word   = DATA_W'({3'b101, rd_addr_d1});

  assign mem_rd_en   = (state == S_BURST);
  assign mem_rd_addr = addr;
  assign busy        = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    state_nx   = state;
    latch_cfg  = 1'b0;
    clr_run    = 1'b0;
    cap_req_nx = 1'b0;
    case (state)
      S_IDLE: begin
        // No capture is stored yet, so a replay request has nothing to read.
        if (start_pe) begin
          state_nx   = S_WAIT_CAP;
          cap_req_nx = 1'b1;
          latch_cfg  = 1'b1;
        end
      end
      S_WAIT_CAP: begin
        if (cap_done) begin
          state_nx = S_BURST;
          clr_run  = 1'b1;
        end
      end
      S_BURST: begin
        // The final memory word always lands on a packet boundary.
        if (last_word) begin
          state_nx = last_addr ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          state_nx = S_BURST;
        end
      end
      S_DONE: begin
        if (start_pe) begin
          state_nx   = S_WAIT_CAP;
          cap_req_nx = 1'b1;
          latch_cfg  = 1'b1;
        end else if (again_pe) begin
          state_nx  = S_BURST;
          clr_run   = 1'b1;
          latch_cfg = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pktctrl_clk) begin
    if (!pktctrl_rstn) begin
      state          <= S_IDLE;
      start_d        <= 1'b0;
      again_d        <= 1'b0;
      rel_q          <= 1'b0;
      cap_req        <= 1'b0;
      addr           <= '0;
      word_cnt       <= '0;
      gap_cnt        <= '0;
      pkt_cnt        <= '0;
      len_q          <= '0;
      idle_q         <= '0;
      st_q           <= 1'b0;
      rd_en_d1       <= 1'b0;
      rd_addr_d1     <= '0;
      ADC_DATA       <= '0;
      ADC_DATA_VALID <= 1'b0;
    end else begin
      state   <= state_nx;
      start_d <= rf_capture_start;
      again_d <= rf_capture_again;
      rel_q   <= 1'b1;
      cap_req <= cap_req_nx;

      if (latch_cfg) begin
        len_q  <= 12'd256 << rf_pkt_data_length;
        idle_q <= (rf_pkt_idle_length == 16'd0) ? 16'd1 : rf_pkt_idle_length;
        st_q   <= rf_self_test_mode;
      end

      if (clr_run) begin
        addr     <= '0;
        word_cnt <= '0;
        pkt_cnt  <= '0;
      end else if (state == S_BURST) begin
        addr <= addr + 1'b1;
        if (last_word) begin
          // Packet closes here whether the next state is GAP or DONE.
          word_cnt <= '0;
          gap_cnt  <= '0;
          pkt_cnt  <= pkt_cnt + 16'd1;
        end else begin
          word_cnt <= word_cnt + 12'd1;
        end
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + 16'd1;
      end

      // Read data arrives one cycle after the strobe; register it onto the pads.
      rd_en_d1       <= mem_rd_en;
      rd_addr_d1     <= addr;
      ADC_DATA_VALID <= rd_en_d1;
      if (rd_en_d1) begin
        ADC_DATA <= st_q ? st_word : mem_rd_data;
      end else begin
        ADC_DATA <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pkt_readout_ctrl.sv
// Purpose : self-checking bench for pkt_readout_ctrl (vector table + readout stream checks).
// Latency : checks sample on the falling edge, one rising edge after inputs are applied.
// Flow    : memory model answers every read one cycle later with addr+7.
module tb_pkt_readout_ctrl;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 18;
  localparam int MEM_DEPTH = 4096;

  logic              pktctrl_clk;
  logic              pktctrl_rstn;
  logic              rf_capture_start;
  logic              rf_capture_again;
  logic              rf_self_test_mode;
  logic [1:0]        rf_pkt_data_length;
  logic [15:0]       rf_pkt_idle_length;
  logic              cap_req;
  logic              cap_done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] ADC_DATA;
  logic              ADC_DATA_VALID;
  logic              busy;
  logic [15:0]       pkt_cnt;

  int checks = 0;
  int errors = 0;

  pkt_readout_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .pktctrl_clk       (pktctrl_clk),
    .pktctrl_rstn      (pktctrl_rstn),
    .rf_capture_start  (rf_capture_start),
    .rf_capture_again  (rf_capture_again),
    .rf_self_test_mode (rf_self_test_mode),
    .rf_pkt_data_length(rf_pkt_data_length),
    .rf_pkt_idle_length(rf_pkt_idle_length),
    .cap_req           (cap_req),
    .cap_done          (cap_done),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_data       (mem_rd_data),
    .ADC_DATA          (ADC_DATA),
    .ADC_DATA_VALID    (ADC_DATA_VALID),
    .busy              (busy),
    .pkt_cnt           (pkt_cnt)
  );

  initial pktctrl_clk = 1'b0;
  always #5 pktctrl_clk = ~pktctrl_clk;

  // Capture memory: word = address + 7, one-cycle read latency.
  initial mem_rd_data = '0;
  always @(posedge pktctrl_clk) begin
    if (mem_rd_en) mem_rd_data <= {3'b000, mem_rd_addr} + 18'd7;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge pktctrl_clk);
  endtask

  typedef struct {
    logic        rstn, start, again, done;
    logic        req, bsy, rd, vld;
    logic [14:0] addr;
    logic [17:0] dat;
  } vec_t;

  vec_t vec[13];

  task automatic set_vec(input int i, input int rstn, input int start, input int again,
                         input int done, input int req, input int bsy, input int rd,
                         input int vld, input int addr, input int dat);
    vec[i].rstn  = 1'(rstn);
    vec[i].start = 1'(start);
    vec[i].again = 1'(again);
    vec[i].done  = 1'(done);
    vec[i].req   = 1'(req);
    vec[i].bsy   = 1'(bsy);
    vec[i].rd    = 1'(rd);
    vec[i].vld   = 1'(vld);
    vec[i].addr  = 15'(addr);
    vec[i].dat   = 18'(dat);
  endtask

  // Expected pad-bus valid for output cycle c of a run (cycle 0 = first valid word).
  function automatic bit exp_vld(input int c, input int len, input int period, input int c_last);
    return (c >= 0) && (c <= c_last) && ((c % period) < len);
  endfunction

  function automatic logic [17:0] exp_word(input int a, input bit st);
    logic [14:0] a15;
    a15 = 15'(a);
    return st ? {3'b101, a15} : ({3'b000, a15} + 18'd7);
  endfunction

  // Checks a readout run from output cycle p to a few cycles past its end.
  task automatic stream(input int p, input int len, input int idle, input bit st,
                        input int stop_at, input int chg_at);
    int period, npk, c_last, pk, off, a;
    bit v, v2;
    period = len + idle;
    npk    = MEM_DEPTH / len;
    c_last = (npk - 1) * period + len - 1;
    for (int c = p; c <= c_last + 3; c++) begin
      tick();
      if (c == chg_at) rf_pkt_data_length = 2'd2;
      pk  = c / period;
      off = c % period;
      v   = exp_vld(c, len, period, c_last);
      v2  = exp_vld(c + 2, len, period, c_last);
      a   = pk * len + off;
      chk($sformatf("c%0d valid", c), 32'(ADC_DATA_VALID), 32'(v));
      chk($sformatf("c%0d data", c), 32'(ADC_DATA), v ? 32'(exp_word(a, st)) : 32'd0);
      chk($sformatf("c%0d busy", c), 32'(busy), 32'(c < c_last - 1));
      chk($sformatf("c%0d rd_en", c), 32'(mem_rd_en), 32'(v2));
      if (v2) begin
        a = ((c + 2) / period) * len + ((c + 2) % period);
        chk($sformatf("c%0d rd_addr", c), 32'(mem_rd_addr), 32'(a));
      end
      if (v && off == 0) chk($sformatf("c%0d pkt_cnt", c), 32'(pkt_cnt), 32'(pk));
      if (c == stop_at) return;
    end
    chk("run pkt_cnt", 32'(pkt_cnt), 32'(npk));
  endtask

  // Launches a run by start (optionally with again) or by again alone,
  // leaving the bench one cycle before output cycle 0.
  task automatic kick(input bit use_start, input bit use_again);
    rf_capture_start = use_start;
    rf_capture_again = use_again;
    tick();
    if (use_start) begin
      chk("kick cap_req", 32'(cap_req), 32'd1);
      chk("kick no rd", 32'(mem_rd_en), 32'd0);
      chk("kick busy", 32'(busy), 32'd1);
      rf_capture_start = 1'b0;
      rf_capture_again = 1'b0;
      tick();
      chk("kick cap_req pulse", 32'(cap_req), 32'd0);
      tick();
      tick();
      chk("kick wait rd", 32'(mem_rd_en), 32'd0);
      cap_done = 1'b1;
      tick();
      cap_done = 1'b0;
    end else begin
      rf_capture_again = 1'b0;
      chk("again no cap_req", 32'(cap_req), 32'd0);
    end
    chk("kick rd_en", 32'(mem_rd_en), 32'd1);
    chk("kick addr0", 32'(mem_rd_addr), 32'd0);
    chk("kick pkt_cnt0", 32'(pkt_cnt), 32'd0);
    chk("kick busy run", 32'(busy), 32'd1);
    tick();
    chk("kick vld lag", 32'(ADC_DATA_VALID), 32'd0);
  endtask

  initial begin
    pktctrl_rstn       = 1'b0;
    rf_capture_start   = 1'b0;
    rf_capture_again   = 1'b0;
    rf_self_test_mode  = 1'b0;
    rf_pkt_data_length = 2'd0;
    rf_pkt_idle_length = 16'd4;
    cap_done           = 1'b0;

    //          i  rstn st ag dn  req bsy rd vld addr dat
    set_vec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // reset state
    set_vec( 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_vec( 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);   // again in IDLE: ignored
    set_vec( 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_vec( 4, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);   // start edge -> cap_req
    set_vec( 5, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);   // held level: single pulse
    set_vec( 6, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0);   // cap_done -> read addr 0
    set_vec( 7, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0);
    set_vec( 8, 1, 0, 0, 0, 0, 1, 1, 1, 2, 7);   // first word, 2 cycles after rd
    set_vec( 9, 1, 1, 0, 0, 0, 1, 1, 1, 3, 8);   // start edge mid-burst: ignored
    set_vec(10, 1, 1, 0, 1, 0, 1, 1, 1, 4, 9);   // spurious cap_done: ignored
    set_vec(11, 1, 1, 0, 0, 0, 1, 1, 1, 5, 10);
    set_vec(12, 1, 1, 0, 0, 0, 1, 1, 1, 6, 11);

    tick();
    tick();
    for (int i = 0; i < 13; i++) begin
      pktctrl_rstn     = vec[i].rstn;
      rf_capture_start = vec[i].start;
      rf_capture_again = vec[i].again;
      cap_done         = vec[i].done;
      tick();
      chk($sformatf("vec%0d cap_req", i), 32'(cap_req), 32'(vec[i].req));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vec[i].bsy));
      chk($sformatf("vec%0d rd_en", i), 32'(mem_rd_en), 32'(vec[i].rd));
      chk($sformatf("vec%0d valid", i), 32'(ADC_DATA_VALID), 32'(vec[i].vld));
      chk($sformatf("vec%0d addr", i), 32'(mem_rd_addr), 32'(vec[i].addr));
      chk($sformatf("vec%0d data", i), 32'(ADC_DATA), 32'(vec[i].dat));
      chk($sformatf("vec%0d pkt_cnt", i), 32'(pkt_cnt), 32'd0);
    end
    cap_done = 1'b0;
    // Basic run continues from output cycle 5: 256-word packets, 4 idle.
    stream(5, 256, 4, 1'b0, -1, -1);

    // Idle clamp + max length, launched by simultaneous start and again in DONE.
    rf_capture_start   = 1'b0;
    rf_pkt_data_length = 2'd3;
    rf_pkt_idle_length = 16'd0;
    tick();
    kick(1'b1, 1'b1);
    stream(0, 2048, 1, 1'b0, -1, -1);

    // Length change during a gap only affects the next start.
    rf_pkt_data_length = 2'd0;
    rf_pkt_idle_length = 16'd3;
    tick();
    kick(1'b1, 1'b0);
    stream(0, 256, 3, 1'b0, -1, 257);
    tick();
    kick(1'b1, 1'b0);
    stream(0, 1024, 3, 1'b0, -1, -1);

    // Self-test replay from DONE: no capture request, pkt_cnt restarts.
    rf_self_test_mode  = 1'b1;
    rf_pkt_idle_length = 16'd2;
    tick();
    kick(1'b0, 1'b1);
    stream(0, 1024, 2, 1'b1, -1, -1);

    // Reset on word 100 of packet 3 with start held high.
    rf_self_test_mode  = 1'b0;
    rf_pkt_data_length = 2'd0;
    rf_pkt_idle_length = 16'd4;
    tick();
    kick(1'b1, 1'b0);
    stream(0, 256, 4, 1'b0, 3 * 260 + 100, -1);
    rf_capture_start = 1'b1;
    tick();
    pktctrl_rstn = 1'b0;
    tick();
    chk("rst valid", 32'(ADC_DATA_VALID), 32'd0);
    chk("rst data", 32'(ADC_DATA), 32'd0);
    chk("rst rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst addr", 32'(mem_rd_addr), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cap_req", 32'(cap_req), 32'd0);
    chk("rst pkt_cnt", 32'(pkt_cnt), 32'd0);
    pktctrl_rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("held start %0d cap_req", i), 32'(cap_req), 32'd0);
      chk($sformatf("held start %0d busy", i), 32'(busy), 32'd0);
    end
    rf_capture_start = 1'b0;
    tick();
    chk("start low cap_req", 32'(cap_req), 32'd0);
    kick(1'b1, 1'b0);
    stream(0, 256, 4, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
